// File: rtl/ws2812_frame_sched.sv
// ws2812_frame_sched
// Runs one LED frame per frame-period tick. For each rising edge of the
// downstream pixel_req it fetches one pixel from the source that was latched
// at frame start, scales it by the latched brightness and presents it as a
// one-cycle pulse. Frame boundaries, source timeouts and overruns are flagged.
// SRC_TIMEOUT is expected to be at least 1.

module ws2812_frame_sched #(
    parameter int NUM_PIXEL    = 444,
    parameter int FRAME_PERIOD = 1666666,
    parameter int SRC_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_en,
    input  logic        src_sel,
    input  logic [7:0]  brightness,
    output logic        s0_req,
    input  logic [23:0] s0_data,
    input  logic        s0_vld,
    output logic        s1_req,
    input  logic [23:0] s1_data,
    input  logic        s1_vld,
    input  logic        pixel_req,
    output logic [23:0] pixel_data,
    output logic        pixel_data_vld,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy,
    output logic        timeout_err,
    output logic        frame_overrun
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_WAIT_REQ,
        ST_FETCH,
        ST_OUT,
        ST_DONE
    } state_t;

    localparam logic [23:0] TMR_LAST  = 24'(FRAME_PERIOD - 1);
    localparam logic [8:0]  PIX_LAST  = 9'(NUM_PIXEL - 1);
    localparam logic [7:0]  WAIT_LAST = 8'(SRC_TIMEOUT);
    // One cycle before the limit: zero data and the error flag are
    // registered here so they become visible exactly when the limit is hit.
    localparam logic [7:0]  WAIT_ARM  = 8'(SRC_TIMEOUT - 1);

    // Per-channel scale: (c * (b + 1)) >> 8 on a 17-bit product.
    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] prod;
        prod = {9'd0, c} * ({9'd0, b} + 17'd1);
        return 8'(prod >> 8);
    endfunction

    function automatic logic [23:0] scale_pixel(input logic [23:0] p, input logic [7:0] b);
        return {scale_chan(p[23:16], b), scale_chan(p[15:8], b), scale_chan(p[7:0], b)};
    endfunction

    // ------------------------------------------------------------------
    // Frame timer
    // ------------------------------------------------------------------
    logic [23:0] tmr_q, tmr_d;
    logic        tick;

    // Count 0..FRAME_PERIOD-1 while enabled; terminal count is the tick.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a variable unassigned and no latch is inferred.
        tick  = 1'b0;
        tmr_d = '0;
        if (frame_en) begin
            if (tmr_q == TMR_LAST) begin
                tick = 1'b1;
            end else begin
                tmr_d = tmr_q + 24'd1;
            end
        end
    end

    // Timer register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    // ------------------------------------------------------------------
    // pixel_req edge detector (runs in every state)
    // ------------------------------------------------------------------
    logic req_q, req_d;
    logic req_edge;

    // Rising edge = request high now, low on the previous cycle.
    always_comb begin
        req_d    = pixel_req;
        req_edge = pixel_req & ~req_q;
    end

    // Edge-detector history register.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= 1'b0;
        end else begin
            req_q <= req_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic [7:0]  bright_q, bright_d;
    logic [8:0]  pix_q, pix_d;
    logic [7:0]  wait_q, wait_d;
    logic [23:0] pixel_data_q, pixel_data_d;
    logic        timeout_err_q, timeout_err_d;

    logic        sel_vld;
    logic [23:0] sel_data;

    // Route the frame's latched source; the other source is ignored.
    always_comb begin
        sel_vld  = sel_q ? s1_vld  : s0_vld;
        sel_data = sel_q ? s1_data : s0_data;
    end

    // Next-state, datapath updates and per-state output pulses.
    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        bright_d       = bright_q;
        pix_d          = pix_q;
        wait_d         = wait_q;
        pixel_data_d   = pixel_data_q;
        timeout_err_d  = 1'b0;
        s0_req         = 1'b0;
        s1_req         = 1'b0;
        pixel_data_vld = 1'b0;
        frame_start    = 1'b0;
        frame_done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_LATCH;
                end
            end

            ST_LATCH: begin
                sel_d       = src_sel;
                bright_d    = brightness;
                pix_d       = '0;
                frame_start = 1'b1;
                state_d     = ST_WAIT_REQ;
            end

            ST_WAIT_REQ: begin
                wait_d = '0;
                if (req_edge) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                // The wait counter is zero only on the first FETCH cycle.
                if (wait_q == '0) begin
                    s0_req = ~sel_q;
                    s1_req = sel_q;
                end
                if (wait_q == WAIT_LAST) begin
                    // Zero pixel and error were registered last cycle.
                    state_d = ST_OUT;
                end else if (sel_vld) begin
                    pixel_data_d = scale_pixel(sel_data, bright_q);
                    state_d      = ST_OUT;
                end else if (wait_q == WAIT_ARM) begin
                    pixel_data_d  = 24'h000000;
                    timeout_err_d = 1'b1;
                    wait_d        = WAIT_LAST;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            ST_OUT: begin
                pixel_data_vld = 1'b1;
                if (pix_q == PIX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    pix_d   = pix_q + 9'd1;
                    state_d = ST_WAIT_REQ;
                end
            end

            ST_DONE: begin
                frame_done = 1'b1;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sel_q         <= 1'b0;
            bright_q      <= '0;
            pix_q         <= '0;
            wait_q        <= '0;
            pixel_data_q  <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            bright_q      <= bright_d;
            pix_q         <= pix_d;
            wait_q        <= wait_d;
            pixel_data_q  <= pixel_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Status outputs: a tick outside IDLE is reported and otherwise dropped.
    always_comb begin
        busy          = (state_q != ST_IDLE);
        frame_overrun = tick && (state_q != ST_IDLE);
        pixel_data    = pixel_data_q;
        timeout_err   = timeout_err_q;
    end

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Directed bench for ws2812_frame_sched with NUM_PIXEL=4, FRAME_PERIOD=200,
// SRC_TIMEOUT=8. Inputs change and outputs are sampled on the falling edge.

module tb_ws2812_frame_sched;

    localparam int NP = 4;
    localparam int FP = 200;
    localparam int ST = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_en;
    logic        src_sel;
    logic [7:0]  brightness;
    logic        s0_req, s1_req;
    logic [23:0] s0_data, s1_data;
    logic        s0_vld, s1_vld;
    logic        pixel_req;
    logic [23:0] pixel_data;
    logic        pixel_data_vld;
    logic        frame_start, frame_done, busy, timeout_err, frame_overrun;

    // Source models: answer on the req cycle when auto is set, or force vld.
    logic s0_auto, s0_force, s1_auto, s1_force;
    assign s0_vld = s0_force | (s0_auto & s0_req);
    assign s1_vld = s1_force | (s1_auto & s1_req);

    always #5 clk = ~clk;

    ws2812_frame_sched #(
        .NUM_PIXEL   (NP),
        .FRAME_PERIOD(FP),
        .SRC_TIMEOUT (ST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_en      (frame_en),
        .src_sel       (src_sel),
        .brightness    (brightness),
        .s0_req        (s0_req),
        .s0_data       (s0_data),
        .s0_vld        (s0_vld),
        .s1_req        (s1_req),
        .s1_data       (s1_data),
        .s1_vld        (s1_vld),
        .pixel_req     (pixel_req),
        .pixel_data    (pixel_data),
        .pixel_data_vld(pixel_data_vld),
        .frame_start   (frame_start),
        .frame_done    (frame_done),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .frame_overrun (frame_overrun)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event counters sampled on the falling edge.
    int n_vld = 0, n_s0req = 0, n_s1req = 0, n_fs = 0, n_fd = 0, n_to = 0, n_ovr = 0;
    always @(negedge clk) begin
        if (pixel_data_vld === 1'b1) n_vld++;
        if (s0_req === 1'b1) n_s0req++;
        if (s1_req === 1'b1) n_s1req++;
        if (frame_start === 1'b1) n_fs++;
        if (frame_done === 1'b1) n_fd++;
        if (timeout_err === 1'b1) n_to++;
        if (frame_overrun === 1'b1) n_ovr++;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int rel_cyc  = 0;

    // Wait (bounded) for the frame_start pulse; returns on the LATCH cycle.
    task automatic wait_fs(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_frame_start: not seen within 500 cycles", name);
        end
    endtask

    // One request edge; returns latency (edge cycle to vld) and the pixel.
    task automatic do_pixel(output int lat, output logic [23:0] got);
        int r;
        bit seen;
        @(negedge clk);
        r = cyc;
        pixel_req = 1'b1;
        seen = 1'b0;
        lat = -1;
        got = 'x;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) pixel_req = 1'b0;
            if (pixel_data_vld === 1'b1) begin
                lat  = cyc - r;
                got  = pixel_data;
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL pixel_vld_timeout: no pixel_data_vld within 40 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pixel_data_vld, frame_start, frame_done, busy, timeout_err, frame_overrun,
             s0_req, s1_req} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got=%b exp=00000000", {pixel_data_vld, frame_start,
                     frame_done, busy, timeout_err, frame_overrun, s0_req, s1_req});
        end
        n_checks++;
        if (pixel_data !== 24'h000000) begin
            n_fail++;
            $display("FAIL reset_pixel_data: got=%h exp=000000", pixel_data);
        end
        @(negedge clk);
        rst = 1'b0;
        rel_cyc = cyc;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got=%b exp=0", busy);
        end
    endtask

    task automatic test_basic();
        logic [23:0] px [4];
        int lat;
        logic [23:0] got;
        int s1b, vb;
        px = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
        src_sel = 1'b0;
        brightness = 8'hFF;
        s0_auto = 1'b1;
        wait_fs("basic");
        n_checks++;
        if (cyc - rel_cyc !== FP) begin
            n_fail++;
            $display("FAIL basic_first_tick: got=%0d exp=%0d", cyc - rel_cyc, FP);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy_at_start: got=%b exp=1", busy);
        end
        #1;
        s1b = n_s1req;
        vb  = n_vld;
        for (int p = 0; p < NP; p++) begin
            s0_data = px[p];
            do_pixel(lat, got);
            n_checks++;
            if (got !== px[p]) begin
                n_fail++;
                $display("FAIL basic_data_%0d: got=%h exp=%h", p, got, px[p]);
            end
            n_checks++;
            if (lat !== 2) begin
                n_fail++;
                $display("FAIL basic_latency_%0d: got=%0d exp=2", p, lat);
            end
        end
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_frame_done: got=%b exp=1", frame_done);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, frame_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_back_to_idle: got=%b exp=00", {busy, frame_done});
        end
        #1;
        n_checks++;
        if (n_vld - vb !== NP) begin
            n_fail++;
            $display("FAIL basic_vld_count: got=%0d exp=%0d", n_vld - vb, NP);
        end
        n_checks++;
        if (n_s1req - s1b !== 0) begin
            n_fail++;
            $display("FAIL basic_s1_req: got=%0d exp=0", n_s1req - s1b);
        end
    endtask

    task automatic test_scaling();
        int lat;
        logic [23:0] got;
        int s1b;
        src_sel = 1'b0;
        brightness = 8'h7F;
        s0_auto = 1'b1;
        s1_auto = 1'b1;
        s1_data = 24'hFFFFFF;
        wait_fs("scale");
        #1;
        s1b = n_s1req;
        s0_data = 24'h80FF00;
        do_pixel(lat, got);
        n_checks++;
        if (got !== 24'h407F00) begin
            n_fail++;
            $display("FAIL scale_7f: got=%h exp=407f00", got);
        end
        // Mid-frame changes must not affect the latched brightness or source.
        brightness = 8'h00;
        s0_data = 24'h123456;
        do_pixel(lat, got);
        n_checks++;
        if (got !== 24'h091A2B) begin
            n_fail++;
            $display("FAIL scale_bright_held: got=%h exp=091a2b", got);
        end
        s0_data = 24'hFFFFFF;
        do_pixel(lat, got);
        n_checks++;
        if (got !== 24'h7F7F7F) begin
            n_fail++;
            $display("FAIL scale_ff_7f: got=%h exp=7f7f7f", got);
        end
        src_sel = 1'b1;
        s0_data = 24'h020406;
        do_pixel(lat, got);
        n_checks++;
        if (got !== 24'h010203) begin
            n_fail++;
            $display("FAIL scale_src_held: got=%h exp=010203", got);
        end
        @(negedge clk);
        src_sel = 1'b0;
        #1;
        n_checks++;
        if (n_s1req - s1b !== 0) begin
            n_fail++;
            $display("FAIL scale_s1_req: got=%0d exp=0", n_s1req - s1b);
        end
        // Next frame latches brightness 0.
        s1_auto = 1'b0;
        brightness = 8'h00;
        wait_fs("scale0");
        s0_data = 24'hFFFFFF;
        do_pixel(lat, got);
        n_checks++;
        if (got !== 24'h000000) begin
            n_fail++;
            $display("FAIL scale_zero: got=%h exp=000000", got);
        end
        for (int p = 1; p < NP; p++) do_pixel(lat, got);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int lat, r, to_at, vld_at, s0b, tob, fdb;
        logic [23:0] got, to_data, vld_data;
        src_sel = 1'b1;
        brightness = 8'hFF;
        s1_auto = 1'b1;
        s1_data = 24'hABCDEF;
        wait_fs("timeout");
        #1;
        s0b = n_s0req;
        tob = n_to;
        fdb = n_fd;
        do_pixel(lat, got);
        n_checks++;
        if (got !== 24'hABCDEF) begin
            n_fail++;
            $display("FAIL timeout_s1_data: got=%h exp=abcdef", got);
        end
        s1_auto  = 1'b0;
        s0_force = 1'b1;
        @(negedge clk);
        r = cyc;
        pixel_req = 1'b1;
        to_at = -1;
        vld_at = -1;
        to_data = 'x;
        vld_data = 'x;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) pixel_req = 1'b0;
            if (timeout_err === 1'b1 && to_at < 0) begin
                to_at   = cyc - r;
                to_data = pixel_data;
            end
            if (pixel_data_vld === 1'b1) begin
                vld_at   = cyc - r;
                vld_data = pixel_data;
                break;
            end
        end
        n_checks++;
        if (to_at !== ST + 1) begin
            n_fail++;
            $display("FAIL timeout_err_cycle: got=%0d exp=%0d", to_at, ST + 1);
        end
        n_checks++;
        if (to_data !== 24'h000000) begin
            n_fail++;
            $display("FAIL timeout_data_at_err: got=%h exp=000000", to_data);
        end
        n_checks++;
        if (vld_at !== ST + 2) begin
            n_fail++;
            $display("FAIL timeout_vld_cycle: got=%0d exp=%0d", vld_at, ST + 2);
        end
        n_checks++;
        if (vld_data !== 24'h000000) begin
            n_fail++;
            $display("FAIL timeout_vld_data: got=%h exp=000000", vld_data);
        end
        do_pixel(lat, got);
        n_checks++;
        if (lat !== ST + 2) begin
            n_fail++;
            $display("FAIL timeout_latency: got=%0d exp=%0d", lat, ST + 2);
        end
        do_pixel(lat, got);
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_frame_done: got=%b exp=1", frame_done);
        end
        s0_force = 1'b0;
        src_sel  = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (n_to - tob !== 3) begin
            n_fail++;
            $display("FAIL timeout_err_count: got=%0d exp=3", n_to - tob);
        end
        n_checks++;
        if (n_s0req - s0b !== 0) begin
            n_fail++;
            $display("FAIL timeout_s0_req: got=%0d exp=0", n_s0req - s0b);
        end
        n_checks++;
        if (n_fd - fdb !== 1) begin
            n_fail++;
            $display("FAIL timeout_done_count: got=%0d exp=1", n_fd - fdb);
        end
    endtask

    task automatic test_overrun();
        int fsc, fsb, ovb, at, lat;
        logic [23:0] got;
        src_sel = 1'b0;
        brightness = 8'hFF;
        s0_auto = 1'b1;
        wait_fs("overrun");
        fsc = cyc;
        #1;
        fsb = n_fs;
        ovb = n_ovr;
        at = -1;
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            if (frame_overrun === 1'b1) begin
                at = cyc - fsc;
                break;
            end
        end
        n_checks++;
        if (at !== FP - 1) begin
            n_fail++;
            $display("FAIL overrun_cycle: got=%0d exp=%0d", at, FP - 1);
        end
        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if (n_fs - fsb !== 0) begin
            n_fail++;
            $display("FAIL overrun_no_restart: got=%0d exp=0", n_fs - fsb);
        end
        n_checks++;
        if (n_ovr - ovb !== 1) begin
            n_fail++;
            $display("FAIL overrun_pulse_count: got=%0d exp=1", n_ovr - ovb);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_still_busy: got=%b exp=1", busy);
        end
        s0_data = 24'h0F1E2D;
        do_pixel(lat, got);
        n_checks++;
        if (got !== 24'h0F1E2D) begin
            n_fail++;
            $display("FAIL overrun_first_pixel: got=%h exp=0f1e2d", got);
        end
        for (int p = 1; p < NP; p++) do_pixel(lat, got);
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_frame_done: got=%b exp=1", frame_done);
        end
        @(negedge clk);
    endtask

    task automatic test_held_req();
        int vb, s0b, lat;
        logic [23:0] got;
        s0_auto = 1'b1;
        s0_data = 24'h336699;
        wait_fs("held");
        #1;
        vb  = n_vld;
        s0b = n_s0req;
        @(negedge clk);
        pixel_req = 1'b1;
        repeat (20) @(negedge clk);
        pixel_req = 1'b0;
        #1;
        n_checks++;
        if (n_vld - vb !== 1) begin
            n_fail++;
            $display("FAIL held_vld_count: got=%0d exp=1", n_vld - vb);
        end
        n_checks++;
        if (n_s0req - s0b !== 1) begin
            n_fail++;
            $display("FAIL held_fetch_count: got=%0d exp=1", n_s0req - s0b);
        end
        // Toggle pixel_req while the fetch is stalled and during OUT.
        vb  = n_vld;
        s0b = n_s0req;
        s0_auto = 1'b0;
        s0_data = 24'h5A5A5A;
        @(negedge clk) pixel_req = 1'b1;
        @(negedge clk) pixel_req = 1'b0;
        @(negedge clk) pixel_req = 1'b1;
        @(negedge clk) pixel_req = 1'b0;
        @(negedge clk) pixel_req = 1'b1;
        @(negedge clk);
        pixel_req = 1'b0;
        s0_force  = 1'b1;
        @(negedge clk);
        s0_force  = 1'b0;
        pixel_req = 1'b1;
        n_checks++;
        if ({pixel_data_vld, pixel_data} !== {1'b1, 24'h5A5A5A}) begin
            n_fail++;
            $display("FAIL toggle_out: got=%b/%h exp=1/5a5a5a", pixel_data_vld, pixel_data);
        end
        @(negedge clk) pixel_req = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        n_checks++;
        if (n_vld - vb !== 1) begin
            n_fail++;
            $display("FAIL toggle_vld_count: got=%0d exp=1", n_vld - vb);
        end
        n_checks++;
        if (n_s0req - s0b !== 1) begin
            n_fail++;
            $display("FAIL toggle_fetch_count: got=%0d exp=1", n_s0req - s0b);
        end
        s0_auto = 1'b1;
        do_pixel(lat, got);
        do_pixel(lat, got);
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL held_frame_done: got=%b exp=1", frame_done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int fdb, lat;
        logic [23:0] got;
        s0_auto = 1'b1;
        s0_data = 24'hC0FFEE;
        wait_fs("rstmid");
        do_pixel(lat, got);
        do_pixel(lat, got);
        s0_auto = 1'b0;
        #1;
        fdb = n_fd;
        @(negedge clk) pixel_req = 1'b1;
        @(negedge clk) pixel_req = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, s0_req, s1_req, pixel_data_vld, frame_done, timeout_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL rstmid_flags: got=%b exp=000000",
                     {busy, s0_req, s1_req, pixel_data_vld, frame_done, timeout_err});
        end
        n_checks++;
        if (pixel_data !== 24'h000000) begin
            n_fail++;
            $display("FAIL rstmid_pixel_data: got=%h exp=000000", pixel_data);
        end
        rst = 1'b0;
        rel_cyc = cyc;
        s0_auto = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        n_checks++;
        if (n_fd - fdb !== 0) begin
            n_fail++;
            $display("FAIL rstmid_no_done: got=%0d exp=0", n_fd - fdb);
        end
        wait_fs("rstmid2");
        n_checks++;
        if (cyc - rel_cyc !== FP) begin
            n_fail++;
            $display("FAIL rstmid_timer_restart: got=%0d exp=%0d", cyc - rel_cyc, FP);
        end
        for (int p = 0; p < NP - 1; p++) do_pixel(lat, got);
        @(negedge clk);
        n_checks++;
        if ({frame_done, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL rstmid_early_done: got=%b exp=01", {frame_done, busy});
        end
        do_pixel(lat, got);
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_frame_done: got=%b exp=1", frame_done);
        end
        @(negedge clk);
    endtask

    task automatic test_disable();
        int fsb, ovb, en_c, lat;
        logic [23:0] got;
        s0_auto = 1'b1;
        wait_fs("disable");
        frame_en = 1'b0;
        for (int p = 0; p < NP; p++) do_pixel(lat, got);
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL disable_inflight_done: got=%b exp=1", frame_done);
        end
        #1;
        fsb = n_fs;
        ovb = n_ovr;
        repeat (450) @(negedge clk);
        #1;
        n_checks++;
        if (n_fs - fsb !== 0) begin
            n_fail++;
            $display("FAIL disable_no_start: got=%0d exp=0", n_fs - fsb);
        end
        n_checks++;
        if (n_ovr - ovb !== 0) begin
            n_fail++;
            $display("FAIL disable_no_overrun: got=%0d exp=0", n_ovr - ovb);
        end
        @(negedge clk);
        frame_en = 1'b1;
        en_c = cyc;
        wait_fs("reenable");
        n_checks++;
        if (cyc - en_c !== FP) begin
            n_fail++;
            $display("FAIL reenable_tick: got=%0d exp=%0d", cyc - en_c, FP);
        end
    endtask

    initial begin
        rst        = 1'b1;
        frame_en   = 1'b1;
        src_sel    = 1'b0;
        brightness = 8'hFF;
        s0_data    = '0;
        s1_data    = '0;
        pixel_req  = 1'b0;
        s0_auto    = 1'b0;
        s0_force   = 1'b0;
        s1_auto    = 1'b0;
        s1_force   = 1'b0;
        test_reset();
        test_basic();
        test_scaling();
        test_timeout();
        test_overrun();
        test_held_req();
        test_reset_mid();
        test_disable();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ws2812_frame_sched.md
# ws2812_frame_sched

Frame scheduler that sits upstream of the pixel-to-WS2812 adapter and sequences one full LED frame per frame-period tick. It arbitrates between two pattern sources selected per frame, fetches one pixel per downstream request, applies a global brightness scale, and presents each result as a one-cycle valid pulse. It also reports frame boundaries, source timeouts and frame overruns.

## Interface
- NUM_PIXEL, 444: pixels per frame (max 511).
- FRAME_PERIOD, 1666666: clock cycles between frame ticks (24-bit counter).
- SRC_TIMEOUT, 255: maximum cycles to wait for source data (8-bit counter).
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- frame_en  in  1  enables the frame timer.
- src_sel  in  1  source select (0 = s0, 1 = s1); sampled at frame start.
- brightness  in  8  global scale; sampled at frame start.
- s0_req / s1_req  out  1  one-cycle fetch pulse to the source.
- s0_data / s1_data  in  24  source pixel as GRB, 8 bits per channel.
- s0_vld / s1_vld  in  1  source data valid.
- pixel_req  in  1  pixel request from the downstream adapter.
- pixel_data  out  24  scaled pixel.
- pixel_data_vld  out  1  one-cycle pulse per pixel.
- frame_start  out  1  one-cycle pulse when a frame begins.
- frame_done  out  1  one-cycle pulse after the last pixel.
- busy  out  1  high whenever the state is not IDLE.
- timeout_err  out  1  one-cycle pulse when a source times out.
- frame_overrun  out  1  one-cycle pulse when a tick arrives while not IDLE.

## Operation
- **Frame timer:** counts 0..FRAME_PERIOD-1 while frame_en=1. The terminal count is the tick and wraps the counter to 0. While frame_en=0 the counter is held at 0 and no tick is produced. Deasserting frame_en does not abort a frame already in progress.
- **States:** IDLE, LATCH, WAIT_REQ, FETCH, OUT, DONE.
- **IDLE:** on a tick, go to LATCH.
- **LATCH:** latch src_sel and brightness, clear the pixel counter, pulse frame_start, go to WAIT_REQ.
- **WAIT_REQ:** on a rising edge of pixel_req (pixel_req=1 and its registered copy=0), go to FETCH. The edge detector runs in every state, so an edge that occurs outside WAIT_REQ is dropped.
- **FETCH:**
  - On its first cycle, pulse the selected sN_req. The unselected source's req stays 0.
  - When the selected sN_vld=1 (this may be the req cycle), register the scaled data into pixel_data and go to OUT.
  - If the wait counter reaches SRC_TIMEOUT first, register 24'h000000, pulse timeout_err, and go to OUT.
  - The unselected sN_vld is ignored.
- **OUT:** pixel_data_vld=1 for this one cycle. If the pixel counter = NUM_PIXEL-1, go to DONE. Otherwise increment the counter and go to WAIT_REQ.
- **DONE:** pulse frame_done, go to IDLE.
- **Overrun:** a tick in any state other than IDLE pulses frame_overrun and is otherwise discarded; no frame is queued.
- **Scaling:** each 8-bit channel is computed as c' = (c × (brightness+1)) >> 8, using a 17-bit product and taking bits [15:8].
  - brightness=255 is the identity.
  - brightness=0 yields 0.
- **Output hold:** pixel_data holds its value between pulses.
- **Reset:** state IDLE, all counters 0, all outputs 0 (including pixel_data), edge register 0. Reset mid-frame abandons the frame without a frame_done pulse.

## Timing
- Tick at cycle T → frame_start=1 and busy=1 at T+1 → WAIT_REQ at T+2.
- pixel_req rising edge sampled at cycle R → sN_req=1 at R+1.
- sN_vld=1 at cycle V (V ≥ R+1) → pixel_data_vld=1 with the new pixel_data at V+1.
  - Best case: 2 cycles from the request edge to valid.
- Timeout: if no vld arrives, timeout_err=1 and pixel_data=0 both appear at R+1+SRC_TIMEOUT, and pixel_data_vld=1 follows at R+2+SRC_TIMEOUT.
- Last pixel OUT at cycle L → frame_done=1 at L+1 → IDLE (busy=0) at L+2.
- Consecutive pixel_data_vld pulses are always separated by at least 2 low cycles.
- A frame_en change takes effect on the timer in the next cycle.

## Test plan
Use NUM_PIXEL=4, FRAME_PERIOD=200, SRC_TIMEOUT=8.
- **Basic frame:** src_sel=0, brightness=255, s0 returns 0x112233, 0x445566, 0x778899, 0xAABBCC with vld on the req cycle, pixel_req pulsed 4 times.
  - Required: exactly 4 vld pulses carrying identical data, each 2 cycles after its edge; frame_done 1 cycle after the 4th; s1_req never asserted.
- **Scaling:** brightness=0x7F with data 0x80FF00 → pixel_data=0x407F00. brightness=0 → 0x000000.
- **Timeout:** s1 selected and never asserts vld.
  - Required: timeout_err and pixel_data=0 at R+9, pixel_data_vld at R+10 with pixel_data=0.
  - The frame still completes after 4 pixels.
- **Overrun and sampling:** hold pixel_req low so that a second tick arrives 200 cycles into the frame.
  - Required: frame_overrun pulse, no second frame_start.
  - Changing src_sel/brightness mid-frame has no effect until the next LATCH.
- **Held request:** pixel_req held high across WAIT_REQ produces a single fetch and no repeated fetches; pixel_req toggling while in FETCH/OUT is ignored.
- **Reset and disable:**
  - Synchronous rst asserted during FETCH → next cycle: IDLE, all outputs 0, no frame_done; the next frame restarts at pixel 0.
  - frame_en=0 → no ticks; an in-flight frame still finishes.
